// File: rtl/sr_latch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sr_latch_pkg
// Description : Shared constants, types and the per-bit resolve function for
//               the clocked SR latch replacement.
// Revision    : 1.0 - initial release
// ============================================================================
package sr_latch_pkg;

   // Response to simultaneous set and reset requests
   localparam int POL_HOLD  = 0;
   localparam int POL_SET   = 1;
   localparam int POL_RESET = 2;
   localparam int POL_NAND  = 3;

   // Reset levels: synchronizer flops idle at the inactive (high) request
   // level, stored state idles cleared.
   localparam logic SYNC_RST_LVL = 1'b1;
   localparam logic ST_RST_LVL   = 1'b0;

   // Decoded request pair {s, r} after active-low inversion
   typedef enum logic [1:0] {
      REQ_IDLE  = 2'b00,
      REQ_RESET = 2'b01,
      REQ_SET   = 2'b10,
      REQ_BOTH  = 2'b11
   } req_e;

   // Next values for one latch bit
   typedef struct packed {
      logic st;
      logic q;
      logic qbar;
      logic invalid;
   } bit_res_t;

   // Resolve one bit for the coming edge. The stored state only moves on a
   // set or reset (or a conflicting pair the policy maps to one of those).
   // Outputs follow the stored state, except that the NAND policy forces
   // both outputs high for as long as the conflict lasts while leaving the
   // stored state untouched, so the pre-conflict value reappears afterwards.
   function automatic bit_res_t resolve_bit(
      input int   policy,
      input logic st,
      input logic s,
      input logic r
   );
      bit_res_t res;
      req_e     req;
      req         = req_e'({s, r});
      res.st      = st;
      res.invalid = 1'b0;
      case (req)
         REQ_IDLE:  res.st = st;
         REQ_SET:   res.st = 1'b1;
         REQ_RESET: res.st = 1'b0;
         REQ_BOTH: begin
            res.invalid = 1'b1;
            if (policy == POL_SET) begin
               res.st = 1'b1;
            end else if (policy == POL_RESET) begin
               res.st = 1'b0;
            end
         end
         default:   res.st = st;
      endcase
      res.q    = res.st;
      res.qbar = ~res.st;
      if (res.invalid && (policy == POL_NAND)) begin
         res.q    = 1'b1;
         res.qbar = 1'b1;
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sr_latch_sync.sv
`default_nettype none
// ============================================================================
// Module      : sr_latch_sync
// Description : SYNC_STAGES-deep flop chain per bit for active-low request
//               inputs. Flops reset to the inactive level; depth 0 is a
//               straight pass-through.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_latch_sync
   import sr_latch_pkg::*;
#(
   parameter int WIDTH       = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (SYNC_STAGES == 0) begin : g_bypass
         // No synchronizer: the request feeds the latch registers directly
         logic unused_clk_rst;
         assign unused_clk_rst = &{1'b0, clk, rst_n};
         assign dout = din;
      end else begin : g_chain
         logic [WIDTH-1:0] stage [SYNC_STAGES];

         // Shift requests through the chain; reset parks every stage idle
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < SYNC_STAGES; i++) begin
                  stage[i] <= {WIDTH{SYNC_RST_LVL}};
               end
            end else begin
               stage[0] <= din;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         assign dout = stage[SYNC_STAGES-1];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/sr_latch.sv
`default_nettype none
// ============================================================================
// Module      : sr_latch
// Description : Clocked replacement for a cross-coupled NAND SR latch.
//               WIDTH independent bits with active-low set/reset requests,
//               optional input synchronizers, per-bit conflict flags and a
//               sticky error summary.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_latch
   import sr_latch_pkg::*;
#(
   parameter int WIDTH          = 1,
   parameter int SYNC_STAGES    = 2,
   parameter int INVALID_POLICY = POL_NAND
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sbar,
   input  logic [WIDTH-1:0] rbar,
   input  logic             err_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic [WIDTH-1:0] invalid,
   output logic             err_sticky
);

   // Reject unsupported configurations while elaborating
   generate
      if ((SYNC_STAGES < 0) || (SYNC_STAGES > 4)) begin : g_bad_sync
         $error("sr_latch: SYNC_STAGES=%0d outside 0..4", SYNC_STAGES);
      end
      if ((INVALID_POLICY < POL_HOLD) || (INVALID_POLICY > POL_NAND)) begin : g_bad_policy
         $error("sr_latch: INVALID_POLICY=%0d outside 0..3", INVALID_POLICY);
      end
   endgenerate

   logic [WIDTH-1:0] sbar_sync;
   logic [WIDTH-1:0] rbar_sync;

   sr_latch_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_set (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (sbar),
      .dout  (sbar_sync)
   );

   sr_latch_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_reset (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (rbar),
      .dout  (rbar_sync)
   );

   // One fully independent latch per bit
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      bit_res_t nxt;
      logic     st;
      logic     q_reg;
      logic     qbar_reg;
      logic     inv_reg;

      // Policy mux: next stored state, outputs and conflict flag
      always_comb begin
         nxt = resolve_bit(INVALID_POLICY, st, ~sbar_sync[i], ~rbar_sync[i]);
      end

      // Stored state and output registers; reset overrides without a clock
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st       <= ST_RST_LVL;
            q_reg    <= ST_RST_LVL;
            qbar_reg <= ~ST_RST_LVL;
            inv_reg  <= 1'b0;
         end else begin
            st       <= nxt.st;
            q_reg    <= nxt.q;
            qbar_reg <= nxt.qbar;
            inv_reg  <= nxt.invalid;
         end
      end

      assign q[i]       = q_reg;
      assign qbar[i]    = qbar_reg;
      assign invalid[i] = inv_reg;
   end

   // Sticky error, registered from the invalid flags; a new conflict beats
   // a coincident clear so no event is ever lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sticky <= 1'b0;
      end else if (|invalid) begin
         err_sticky <= 1'b1;
      end else if (err_clr) begin
         err_sticky <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sr_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_latch
// Description : Self-checking bench. Four single-bit instances (one per
//               conflict policy) share one stimulus; a 4-bit unsynchronized
//               instance has its own. Directed scenarios use fixed expected
//               values, the random phase uses a delay-line reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_latch;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic err_clr = 1'b0;
   logic sbar1 = 1'b1;
   logic rbar1 = 1'b1;
   logic [3:0] sbar4 = 4'hF;
   logic [3:0] rbar4 = 4'hF;

   logic [3:0] q_p, qb_p, inv_p, err_p;   // index = policy
   logic [3:0] q_w, qb_w, inv_w;
   logic       err_w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar p = 0; p < 4; p++) begin : g_pol
      sr_latch #(.WIDTH(1), .SYNC_STAGES(2), .INVALID_POLICY(p)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .sbar       (sbar1),
         .rbar       (rbar1),
         .err_clr    (err_clr),
         .q          (q_p[p]),
         .qbar       (qb_p[p]),
         .invalid    (inv_p[p]),
         .err_sticky (err_p[p])
      );
   end

   sr_latch #(.WIDTH(4), .SYNC_STAGES(0), .INVALID_POLICY(3)) u_dut_w4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .sbar       (sbar4),
      .rbar       (rbar4),
      .err_clr    (err_clr),
      .q          (q_w),
      .qbar       (qb_w),
      .invalid    (inv_w),
      .err_sticky (err_w)
   );

   // ---------------- reference model ----------------
   // Each instance sees its inputs delayed by 'depth' edges; then the
   // textbook set/reset/hold table plus the conflict policy applies.
   int         depth [5] = '{2, 2, 2, 2, 0};
   int         pol   [5] = '{0, 1, 2, 3, 3};
   logic [3:0] s_line [5][4];
   logic [3:0] r_line [5][4];
   logic [3:0] m_st [5], m_q [5], m_qb [5], m_inv [5];
   logic       m_err [5];
   logic [3:0] m_in_s, m_in_r, m_sv, m_rv;
   logic       s_b, r_b, both_b;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int m = 0; m < 5; m++) begin
            for (int k = 0; k < 4; k++) begin
               s_line[m][k] = 4'hF;
               r_line[m][k] = 4'hF;
            end
            m_st[m] = 4'h0; m_q[m] = 4'h0; m_qb[m] = 4'hF;
            m_inv[m] = 4'h0; m_err[m] = 1'b0;
         end
      end else begin
         for (int m = 0; m < 5; m++) begin
            m_in_s = (m < 4) ? {3'b111, sbar1} : sbar4;
            m_in_r = (m < 4) ? {3'b111, rbar1} : rbar4;
            if (depth[m] == 0) begin
               m_sv = m_in_s; m_rv = m_in_r;
            end else begin
               m_sv = s_line[m][depth[m]-1]; m_rv = r_line[m][depth[m]-1];
            end
            for (int k = 3; k > 0; k--) begin
               s_line[m][k] = s_line[m][k-1];
               r_line[m][k] = r_line[m][k-1];
            end
            s_line[m][0] = m_in_s;
            r_line[m][0] = m_in_r;
            if (m_inv[m] != 4'h0) m_err[m] = 1'b1;
            else if (err_clr) m_err[m] = 1'b0;
            for (int b = 0; b < 4; b++) begin
               s_b = ~m_sv[b]; r_b = ~m_rv[b]; both_b = s_b & r_b;
               if ((s_b && !r_b) || (both_b && pol[m] == 1)) m_st[m][b] = 1'b1;
               else if ((r_b && !s_b) || (both_b && pol[m] == 2)) m_st[m][b] = 1'b0;
               m_inv[m][b] = both_b;
               if (both_b && pol[m] == 3) begin
                  m_q[m][b] = 1'b1; m_qb[m][b] = 1'b1;
               end else begin
                  m_q[m][b] = m_st[m][b]; m_qb[m][b] = ~m_st[m][b];
               end
            end
         end
      end
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (q_p !== 4'h0)   begin errors++; $display("FAIL reset_q: got %b exp 0000", q_p); end
      checks++; if (qb_p !== 4'hF)  begin errors++; $display("FAIL reset_qbar: got %b exp 1111", qb_p); end
      checks++; if (inv_p !== 4'h0) begin errors++; $display("FAIL reset_invalid: got %b exp 0000", inv_p); end
      checks++; if (err_p !== 4'h0) begin errors++; $display("FAIL reset_err: got %b exp 0000", err_p); end
      checks++; if ({q_w, qb_w, inv_w, err_w} !== {4'h0, 4'hF, 4'h0, 1'b0})
         begin errors++; $display("FAIL reset_w4: got q=%b qb=%b inv=%b err=%b", q_w, qb_w, inv_w, err_w); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_set_hold_reset();
      rbar1 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (q_p[3] !== 1'b0 || qb_p[3] !== 1'b1)
            begin errors++; $display("FAIL rbar_low_q: cycle %0d q=%b qb=%b exp 0/1", i, q_p[3], qb_p[3]); end
      end
      rbar1 = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (q_p[3] !== 1'b0) begin errors++; $display("FAIL hold0_q: got %b exp 0", q_p[3]); end
      sbar1 = 1'b0;
      repeat (2) begin
         @(negedge clk);
         checks++; if (q_p[3] !== 1'b0) begin errors++; $display("FAIL set_latency_early: q=%b exp 0", q_p[3]); end
      end
      @(negedge clk);
      checks++; if (q_p !== 4'hF || qb_p !== 4'h0)
         begin errors++; $display("FAIL set_3edges: q=%b qb=%b exp 1111/0000", q_p, qb_p); end
      sbar1 = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (q_p[3] !== 1'b1 || qb_p[3] !== 1'b0)
         begin errors++; $display("FAIL hold1: q=%b qb=%b exp 1/0", q_p[3], qb_p[3]); end
   endtask

   task automatic test_simultaneous();
      sbar1 = 1'b0; rbar1 = 1'b0;
      repeat (3) @(negedge clk);
      // policies 3..0: q = 1,0,1,1  qbar = 1,1,0,0
      checks++; if (q_p !== 4'b1011)  begin errors++; $display("FAIL both_q: got %b exp 1011", q_p); end
      checks++; if (qb_p !== 4'b1100) begin errors++; $display("FAIL both_qbar: got %b exp 1100", qb_p); end
      checks++; if (inv_p !== 4'hF)   begin errors++; $display("FAIL both_invalid: got %b exp 1111", inv_p); end
      checks++; if (err_p !== 4'h0)   begin errors++; $display("FAIL err_early: got %b exp 0000", err_p); end
      @(negedge clk);
      checks++; if (err_p !== 4'hF)   begin errors++; $display("FAIL err_set: got %b exp 1111", err_p); end
      sbar1 = 1'b1; rbar1 = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (q_p !== 4'b1011 || qb_p !== 4'b0100 || inv_p !== 4'h0)
         begin errors++; $display("FAIL release_both: q=%b qb=%b inv=%b exp 1011/0100/0000", q_p, qb_p, inv_p); end
   endtask

   task automatic test_sticky_clear();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checks++; if (err_p !== 4'h0) begin errors++; $display("FAIL err_clear: got %b exp 0000", err_p); end
      sbar1 = 1'b0; rbar1 = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (inv_p !== 4'hF || err_p !== 4'h0)
         begin errors++; $display("FAIL invalid_again: inv=%b err=%b exp 1111/0000", inv_p, err_p); end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checks++; if (err_p !== 4'hF) begin errors++; $display("FAIL clr_vs_set: got %b exp 1111", err_p); end
      sbar1 = 1'b1; rbar1 = 1'b1;
      repeat (4) @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checks++; if (err_p !== 4'h0) begin errors++; $display("FAIL err_clear2: got %b exp 0000", err_p); end
   endtask

   task automatic test_async_reset();
      sbar1 = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (q_p !== 4'hF) begin errors++; $display("FAIL pre_reset_q: got %b exp 1111", q_p); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (q_p !== 4'h0 || qb_p !== 4'hF)
         begin errors++; $display("FAIL async_reset: q=%b qb=%b exp 0000/1111", q_p, qb_p); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checks++; if (q_p !== 4'h0) begin errors++; $display("FAIL post_reset_early: q=%b exp 0000", q_p); end
      end
      @(negedge clk);
      checks++; if (q_p !== 4'hF || qb_p !== 4'h0)
         begin errors++; $display("FAIL post_reset_set: q=%b qb=%b exp 1111/0000", q_p, qb_p); end
      sbar1 = 1'b1;
   endtask

   task automatic test_multibit();
      sbar4 = 4'b1001; rbar4 = 4'hF;
      @(negedge clk);
      checks++; if (q_w !== 4'b0110 || qb_w !== 4'b1001)
         begin errors++; $display("FAIL w4_preset: q=%b qb=%b exp 0110/1001", q_w, qb_w); end
      sbar4 = 4'b1110; rbar4 = 4'b0111;
      @(negedge clk);
      checks++; if (q_w !== 4'b0111 || qb_w !== 4'b1000 || inv_w !== 4'h0)
         begin errors++; $display("FAIL w4_isolate: q=%b qb=%b inv=%b exp 0111/1000/0000", q_w, qb_w, inv_w); end
      sbar4 = 4'b1010; rbar4 = 4'b1010;
      @(negedge clk);
      checks++; if (inv_w !== 4'b0101 || q_w !== 4'b0111 || qb_w !== 4'b1101)
         begin errors++; $display("FAIL w4_invalid: inv=%b q=%b qb=%b exp 0101/0111/1101", inv_w, q_w, qb_w); end
      sbar4 = 4'hF; rbar4 = 4'hF;
      @(negedge clk);
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         for (int m = 0; m < 4; m++) begin
            checks++;
            if ({q_p[m], qb_p[m], inv_p[m], err_p[m]} !== {m_q[m][0], m_qb[m][0], m_inv[m][0], m_err[m]}) begin
               errors++;
               $display("FAIL rand_pol%0d: cyc %0d q/qb/inv/err=%b%b%b%b exp %b%b%b%b", m, cyc,
                        q_p[m], qb_p[m], inv_p[m], err_p[m], m_q[m][0], m_qb[m][0], m_inv[m][0], m_err[m]);
            end
         end
         checks++;
         if ({q_w, qb_w, inv_w, err_w} !== {m_q[4], m_qb[4], m_inv[4], m_err[4]}) begin
            errors++;
            $display("FAIL rand_w4: cyc %0d q=%b qb=%b inv=%b err=%b exp %b %b %b %b", cyc,
                     q_w, qb_w, inv_w, err_w, m_q[4], m_qb[4], m_inv[4], m_err[4]);
         end
         err_clr = ($urandom_range(0, 3) == 0);
         sbar4 = 4'($urandom);
         rbar4 = 4'($urandom);
         if (hold == 0) begin
            sbar1 = 1'($urandom_range(0, 1));
            rbar1 = 1'($urandom_range(0, 1));
            hold  = $urandom_range(1, 4);
         end else begin
            hold--;
         end
      end
   endtask

   initial begin
      test_reset();
      test_set_hold_reset();
      test_simultaneous();
      test_sticky_clear();
      test_async_reset();
      test_multibit();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/sr_latch.md
# sr_latch

Clocked, synchronous replacement for a cross-coupled NAND SR latch. Holds WIDTH independent bits, each set and reset by active-low request inputs. Requests pass through a configurable synchronizer before reaching a registered state, so the latch can sit on any asynchronous control boundary in a single clock domain. Simultaneous set and reset requests are detected and flagged. Their effect on the outputs is resolved by a compile-time policy.

## Interface
Parameters:
- WIDTH, 1: number of independent latch bits.
- SYNC_STAGES, 2: synchronizer flops per request input. 0 means no synchronizer; legal range 0–4.
- INVALID_POLICY, 3: response to simultaneous requests.
  - 0 = hold.
  - 1 = set wins.
  - 2 = reset wins.
  - 3 = NAND mimic (q = qbar = 1).

Ports:
- clk  in  1  rising-edge system clock.
- rst_n  in  1  reset; asynchronous and active-low.
- sbar  in  WIDTH  set requests, active-low. May be asynchronous to clk.
- rbar  in  WIDTH  reset requests, active-low. May be asynchronous to clk.
- err_clr  in  1  synchronous, active-high clear of err_sticky.
- q  out  WIDTH  latch outputs, registered.
- qbar  out  WIDTH  complement outputs, registered.
- invalid  out  WIDTH  per-bit flag: both requests active in the current resolved cycle.
- err_sticky  out  1  set by any invalid bit; held until err_clr or reset.

## Operation
- Each bit has an internal stored state st, separate from the q/qbar output registers.
- Per bit, s = ~sbar_sync and r = ~rbar_sync. Each clock edge resolves as follows:
  - s=0, r=0: hold. st unchanged; q = st, qbar = ~st.
  - s=1, r=0: st = 1; q = 1, qbar = 0.
  - s=0, r=1: st = 0; q = 0, qbar = 1.
  - s=1, r=1: invalid = 1, and the outputs follow INVALID_POLICY:
    - Policy 0: st unchanged; outputs from st.
    - Policy 1: treated as set.
    - Policy 2: treated as reset.
    - Policy 3: st unchanged; q = 1 and qbar = 1 while the condition persists.
- Leaving the invalid state under policy 3 returns outputs to st, i.e. the pre-invalid value. There is no race or metastable emulation.
- Outside policy 3 invalid cycles, qbar is always exactly ~q.
- err_sticky is set on any cycle where |invalid = 1.
  - err_clr in the same cycle as a new invalid: set wins.
- Bits are fully independent; no cross-bit interaction.

## Timing
- Reset (asynchronous on rst_n falling):
  - q = 0, qbar = all 1, st = 0.
  - invalid = 0, err_sticky = 0.
  - Synchronizer flops = 1, i.e. the inactive request level.
- rst_n must be released synchronously to clk. The first active edge after release evaluates the synchronized requests.
- Reset asserted mid-operation overrides any pending request immediately, with no clock needed. Requests still held low after release take effect after the normal latency.
- Latency from a sbar/rbar edge (meeting setup) to q/qbar/invalid is SYNC_STAGES + 1 clock edges. With the defaults that is 3 edges; with SYNC_STAGES=0 it is 1.
- Request pulses shorter than one clock period are not guaranteed to be captured. Captured requests are level-sensitive; there is no edge detection.
- err_sticky updates one edge after invalid, i.e. it is registered from invalid.
- err_clr takes effect on the next edge.

## Structure
- Package sr_latch_pkg:
  - Policy constants POL_HOLD=0, POL_SET=1, POL_RESET=2, POL_NAND=3.
  - Reset level constants for the synchronizer (1) and for st (0).
- Sub-module sr_latch_sync:
  - SYNC_STAGES-deep flop chain per bit, width WIDTH, reset value 1.
  - Instantiated once for sbar and once for rbar.
  - SYNC_STAGES=0 is a pass-through.
- Top level contains:
  - A generate loop over WIDTH holding the st and output registers and the policy mux.
  - The OR-reduce feeding err_sticky.
- Parameter checks via elaboration-time assertions:
  - SYNC_STAGES range 0–4.
  - INVALID_POLICY range 0–3.

## Test plan
All scenarios use WIDTH=1 and SYNC_STAGES=2 unless stated otherwise.
- Reset: rst_n=0 with sbar=rbar=1 → q=0, qbar=1, invalid=0, err_sticky=0 immediately, with no clock required.
- Set/hold/reset sequence (inputs high = inactive), matching the classic stimulus:
  - rbar low for 5 cycles → q stays 0.
  - rbar back high → q holds 0.
  - sbar low → q=1, qbar=0 exactly 3 edges later.
  - sbar high → q holds 1.
- Simultaneous requests:
  - Policy 3, with q=1 and both inputs low → q=qbar=1, invalid=1, and err_sticky=1 one edge later.
  - Releasing both inputs → q=1, qbar=0.
  - Repeat under policies 0, 1 and 2, expecting q = 1, 1, 0 respectively.
- Sticky clear: err_clr pulse for 1 cycle with no invalid → err_sticky=0. err_clr coincident with a new invalid → err_sticky stays 1.
- Async reset mid-operation: q=1 with sbar held low, then rst_n pulsed low between edges → q=0 at once. After release with sbar still low, q=1 after 3 edges.
- Multi-bit isolation: WIDTH=4, SYNC_STAGES=0, sbar=4'b1110 and rbar=4'b0111 → q=4'b0001 one edge later with bits 1–2 unchanged. sbar=rbar=4'b1010 → invalid=4'b0101 only.
